mem_initiator: RTL and testbench

- Initiator side of the 8-bit / 4K-entry memory pin protocol (cen, rd, wr, address, din, dout).
- Accepts single- or multi-beat requests on a valid/ready interface and drives the memory pins, one beat per clock.
- On reads, captures dout and returns it on a response interface.
- Replaces hand-written stimulus blocks as the driver of the memory in benches and in subsystems that own a memory.

---
 rtl/mem_initiator_if.sv | 32 +++
 rtl/mem_initiator.sv | 137 +++++++++++++
 tb/tb_mem_initiator.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_initiator_if.sv
// Request/response handshake and memory pin bundle for mem_initiator.
// master = initiator side (drives pins and responses), slave = requester/memory side.
interface mem_initiator_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;
  logic              cen;
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (
    input  req_valid, req_wr, req_addr, req_len, req_wdata, dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, cen, rd, wr, address, din
  );
  modport slave (
    output req_valid, req_wr, req_addr, req_len, req_wdata, dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, cen, rd, wr, address, din
  );
endinterface

// File: rtl/mem_initiator.sv
// Burst initiator for the cen/rd/wr memory pin protocol, one beat per clock.
// Optional MEM_INITIATOR_STATS_EN adds saturating write-beat / read-response counters.
module mem_initiator #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int LEN_W        = 4
) (
  input  logic clk,
  input  logic rst,
  mem_initiator_if.master bus,
  output logic busy
`ifdef MEM_INITIATOR_STATS_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
`endif
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] din_q, din_nxt, rsp_data_q;
  logic [LEN_W-1:0]  cnt_q, cnt_nxt;
  logic cen_q, rd_q, wr_q, cen_nxt, rd_nxt, wr_nxt;
  logic ready_q, busy_q, rsp_valid_q, rsp_last_q;
  logic [READ_LATENCY-1:0] vld_pipe, last_pipe;
  logic accept;

  assign accept = (state == IDLE) && bus.req_valid && ready_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Burst states keep one tail cycle with the pins already low before leaving.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.req_wr ? WRITE : READ;
      WRITE:   if (!cen_q) state_nxt = IDLE;
      READ:    if (!cen_q)
                 state_nxt = (|vld_pipe || (rsp_valid_q && !rsp_last_q)) ? DRAIN : IDLE;
      DRAIN:   if (rsp_valid_q && rsp_last_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_nxt = addr_q;
    din_nxt  = din_q;
    cnt_nxt  = cnt_q;
    cen_nxt  = 1'b0;
    rd_nxt   = 1'b0;
    wr_nxt   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        addr_nxt = bus.req_addr;
        din_nxt  = bus.req_wr ? bus.req_wdata : '0;
        cnt_nxt  = bus.req_len;
        cen_nxt  = 1'b1;
        wr_nxt   = bus.req_wr;
        rd_nxt   = !bus.req_wr;
      end
      WRITE, READ: if (cen_q && cnt_q != '0) begin
        addr_nxt = addr_q + ADDR_W'(1);
        din_nxt  = din_q + DATA_W'(wr_q);
        cnt_nxt  = cnt_q - LEN_W'(1);
        cen_nxt  = 1'b1;
        wr_nxt   = wr_q;
        rd_nxt   = rd_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      din_q       <= '0;
      cnt_q       <= '0;
      cen_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      vld_pipe    <= '0;
      last_pipe   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      addr_q  <= addr_nxt;
      din_q   <= din_nxt;
      cnt_q   <= cnt_nxt;
      cen_q   <= cen_nxt;
      rd_q    <= rd_nxt;
      wr_q    <= wr_nxt;
      ready_q <= (state_nxt == IDLE);
      busy_q  <= (state_nxt != IDLE);
      // Stage 0 marks beats whose rd was just sampled by the memory.
      vld_pipe[0]  <= rd_q;
      last_pipe[0] <= rd_q && (cnt_q == '0);
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      rsp_valid_q <= vld_pipe[READ_LATENCY-1];
      rsp_last_q  <= vld_pipe[READ_LATENCY-1] && last_pipe[READ_LATENCY-1];
      if (vld_pipe[READ_LATENCY-1]) rsp_data_q <= bus.dout;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.cen       = cen_q;
  assign bus.rd        = rd_q;
  assign bus.wr        = wr_q;
  assign bus.address   = addr_q;
  assign bus.din       = din_q;
  assign busy          = busy_q;

`ifdef MEM_INITIATOR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_q && wr_count != 16'hFFFF)        wr_count <= wr_count + 16'd1;
      if (rsp_valid_q && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: pin/response monitors, a behavioural memory, and a
// reference model that predicts every beat and response from the request alone.
module tb_mem_initiator;
  localparam int AW = 12, DW = 8, RL = 1, LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
`ifdef MEM_INITIATOR_STATS_EN
  logic [15:0] wr_count, rd_count;
`endif

  mem_initiator_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  mem_initiator #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .LEN_W(LW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy)
`ifdef MEM_INITIATOR_STATS_EN
    ,
    .wr_count(wr_count),
    .rd_count(rd_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, npass = 0;

  // Behavioural memory: rd sampled at an edge, data valid RL edges later.
  logic [7:0] mem [4096];
  logic [7:0] dq [RL];
  logic fill = 1'b1;
  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) ^ (i >> 4));
  endfunction
  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
    else if (bus.wr) mem[bus.address] <= bus.din;
    dq[0] <= mem[bus.address];
    for (int i = 1; i < RL; i++) dq[i] <= dq[i-1];
  end
  assign bus.dout = dq[RL-1];

  typedef struct packed { int cyc; logic w; logic r; logic [11:0] a; logic [7:0] d; } beat_t;
  typedef struct packed { int cyc; logic [7:0] d; logic last; } rsp_t;
  beat_t beats[$];
  rsp_t  rsps[$];
  logic [7:0] exp_d[$];
  logic [7:0] ref_mem [4096];
  int proto_err = 0;

  always @(negedge clk) begin
    if (bus.cen) beats.push_back(beat_t'{cyc, bus.wr, bus.rd, bus.address, bus.din});
    if (bus.rsp_valid) rsps.push_back(rsp_t'{cyc, bus.rsp_rdata, bus.rsp_last});
    if ((bus.rd && bus.wr) || (bus.cen !== (bus.rd | bus.wr))) proto_err++;
  end

  task automatic clear_q();
    beats.delete(); rsps.delete(); exp_d.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents a request, waits for acceptance; acc = cycle in which it was accepted.
  task automatic issue(input bit w, input logic [11:0] a, input logic [3:0] l,
                       input logic [7:0] d, input bit hold, output int acc);
    int t = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = w; bus.req_addr = a; bus.req_len = l; bus.req_wdata = d;
    while (!bus.req_ready && t < 200) begin @(negedge clk); t++; end
    if (!bus.req_ready) begin
      nchk++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", bus.req_ready);
      bus.req_valid = 1'b0; acc = -1;
      return;
    end
    acc = cyc;
    for (int k = 0; k <= int'(l); k++) begin
      if (w) ref_mem[(int'(a) + k) % 4096] = 8'(int'(d) + k);
      else   exp_d.push_back(ref_mem[(int'(a) + k) % 4096]);
    end
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 300) begin @(negedge clk); t++; end
    #1;
    if (busy) begin
      nchk++;
      $display("FAIL idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    fill = 1'b0;
    @(negedge clk);
    nchk++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.req_ready); else npass++;
    nchk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else npass++;
    nchk++; if ({bus.cen, bus.rd, bus.wr} !== 3'b000) $display("FAIL rst_pins: got %b want 000", {bus.cen, bus.rd, bus.wr}); else npass++;
    nchk++; if ({bus.address, bus.din} !== 20'h0) $display("FAIL rst_addr_din: got %h want 0", {bus.address, bus.din}); else npass++;
    nchk++; if ({bus.rsp_valid, bus.rsp_last, bus.rsp_rdata} !== 10'h0) $display("FAIL rst_rsp: got %h want 0", {bus.rsp_valid, bus.rsp_last, bus.rsp_rdata}); else npass++;
  endtask

  task automatic test_single_write();
    int acc, low = 0;
    clear_q();
    issue(1'b1, 12'h010, 4'd0, 8'hA5, 1'b0, acc);
    @(negedge clk);
    while (!bus.req_ready && low < 50) begin low++; @(negedge clk); end
    wait_idle();
    nchk++; if (low !== 2) $display("FAIL single_ready_low: got %0d cycles want 2", low); else npass++;
    nchk++; if (beats.size() !== 1) $display("FAIL single_beats: got %0d want 1", beats.size()); else npass++;
    if (beats.size() > 0) begin
      nchk++; if ({beats[0].w, beats[0].r, beats[0].a, beats[0].d} !== {2'b10, 12'h010, 8'hA5})
        $display("FAIL single_beat: got w%b r%b a%h d%h want w1 r0 a010 dA5", beats[0].w, beats[0].r, beats[0].a, beats[0].d); else npass++;
      nchk++; if (beats[0].cyc !== acc + 1) $display("FAIL single_timing: got cyc %0d want %0d", beats[0].cyc, acc + 1); else npass++;
    end
  endtask

  task automatic test_burst_rw();
    int acc;
    issue(1'b1, 12'h100, 4'd3, 8'h10, 1'b0, acc);
    wait_idle();
    clear_q();
    issue(1'b0, 12'h100, 4'd3, 8'h00, 1'b0, acc);
    wait_idle();
    nchk++; if (rsps.size() !== 4) $display("FAIL rw_count: got %0d want 4", rsps.size()); else npass++;
    for (int i = 0; i < 4 && i < rsps.size(); i++) begin
      nchk++; if (rsps[i].d !== 8'(8'h10 + i)) $display("FAIL rw_data%0d: got %h want %h", i, rsps[i].d, 8'(8'h10 + i)); else npass++;
      nchk++; if (rsps[i].last !== (i == 3)) $display("FAIL rw_last%0d: got %b want %b", i, rsps[i].last, i == 3); else npass++;
      nchk++; if (rsps[i].cyc !== acc + 2 + RL + i) $display("FAIL rw_cyc%0d: got %0d want %0d", i, rsps[i].cyc, acc + 2 + RL + i); else npass++;
    end
    if (beats.size() > 0 && rsps.size() > 0) begin
      nchk++; if (rsps[0].cyc - beats[0].cyc !== RL + 1) $display("FAIL rw_latency: got %0d want %0d", rsps[0].cyc - beats[0].cyc, RL + 1); else npass++;
    end
  endtask

  task automatic test_wrap();
    int acc;
    logic [11:0] ea [4];
    logic [7:0]  ed [4];
    ea = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    ed = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    clear_q();
    issue(1'b1, 12'hFFE, 4'd3, 8'hFE, 1'b0, acc);
    wait_idle();
    nchk++; if (beats.size() !== 4) $display("FAIL wrap_beats: got %0d want 4", beats.size()); else npass++;
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      nchk++; if ({beats[i].a, beats[i].d} !== {ea[i], ed[i]})
        $display("FAIL wrap_beat%0d: got a%h d%h want a%h d%h", i, beats[i].a, beats[i].d, ea[i], ed[i]); else npass++;
    end
  endtask

  task automatic test_back_to_back();
    int acc_a, acc_b;
    clear_q();
    issue(1'b1, 12'h300, 4'd2, 8'h55, 1'b1, acc_a);
    issue(1'b0, 12'h300, 4'd1, 8'h00, 1'b0, acc_b);
    wait_idle();
    nchk++; if (acc_b !== acc_a + 5) $display("FAIL b2b_accept: got cyc %0d want %0d", acc_b, acc_a + 5); else npass++;
    nchk++; if (beats.size() !== 5) $display("FAIL b2b_beats: got %0d want 5", beats.size()); else npass++;
    if (beats.size() == 5) begin
      nchk++; if (beats[3].cyc !== acc_b + 1 || beats[3].r !== 1'b1)
        $display("FAIL b2b_second: got cyc %0d r%b want cyc %0d r1", beats[3].cyc, beats[3].r, acc_b + 1); else npass++;
    end
    nchk++; if (rsps.size() !== 2 || (rsps.size() == 2 && rsps[1].d !== 8'h56))
      $display("FAIL b2b_rsp: got %0d rsps want 2 ending 56", rsps.size()); else npass++;
  endtask

  task automatic test_reset_mid();
    int acc, t = 0;
    clear_q();
    issue(1'b0, 12'h200, 4'd7, 8'h00, 1'b0, acc);
    @(negedge clk); #1;
    while (beats.size() < 2 && t < 20) begin @(negedge clk); #1; t++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nchk++; if ({bus.cen, bus.rd, bus.wr, bus.address, bus.din} !== 23'h0)
      $display("FAIL rstmid_pins: got %h want 0", {bus.cen, bus.rd, bus.wr, bus.address, bus.din}); else npass++;
    nchk++; if (bus.req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rstmid_ready: got ready %b busy %b want 1 0", bus.req_ready, busy); else npass++;
    repeat (15) @(negedge clk);
    nchk++; if (rsps.size() !== 0) $display("FAIL rstmid_rsp: got %0d rsps want 0", rsps.size()); else npass++;
    nchk++; if (beats.size() !== 2) $display("FAIL rstmid_beats: got %0d want 2", beats.size()); else npass++;
  endtask

`ifdef MEM_INITIATOR_STATS_EN
  task automatic test_stats();
    int acc;
    do_reset();
    issue(1'b1, 12'h400, 4'd2, 8'h20, 1'b0, acc);
    wait_idle();
    issue(1'b0, 12'h400, 4'd4, 8'h00, 1'b0, acc);
    wait_idle();
    nchk++; if (wr_count !== 16'd3) $display("FAIL stats_wr: got %0d want 3", wr_count); else npass++;
    nchk++; if (rd_count !== 16'd5) $display("FAIL stats_rd: got %0d want 5", rd_count); else npass++;
    do_reset();
    @(negedge clk);
    nchk++; if ({wr_count, rd_count} !== 32'h0) $display("FAIL stats_clr: got %h want 0", {wr_count, rd_count}); else npass++;
  endtask
`endif

  task automatic test_random();
    int acc;
    bit w;
    logic [11:0] a;
    logic [3:0] l;
    logic [7:0] d;
    for (int n = 0; n < 30; n++) begin
      w = 1'($urandom_range(0, 1));
      a = 12'($urandom);
      l = 4'($urandom);
      d = 8'($urandom);
      clear_q();
      issue(w, a, l, d, 1'b0, acc);
      wait_idle();
      nchk++; if (beats.size() !== int'(l) + 1) $display("FAIL rnd%0d_beats: got %0d want %0d", n, beats.size(), int'(l) + 1); else npass++;
      for (int k = 0; k < beats.size() && k <= int'(l); k++) begin
        nchk++;
        if (beats[k].cyc !== acc + 1 + k || beats[k].w !== w || beats[k].r !== !w ||
            beats[k].a !== 12'(int'(a) + k) || (w && beats[k].d !== 8'(int'(d) + k)))
          $display("FAIL rnd%0d_beat%0d: got cyc%0d w%b a%h d%h want cyc%0d w%b a%h d%h", n, k,
                   beats[k].cyc, beats[k].w, beats[k].a, beats[k].d, acc + 1 + k, w, 12'(int'(a) + k), 8'(int'(d) + k));
        else npass++;
      end
      if (!w) begin
        nchk++; if (rsps.size() !== int'(l) + 1) $display("FAIL rnd%0d_rsps: got %0d want %0d", n, rsps.size(), int'(l) + 1); else npass++;
        for (int k = 0; k < rsps.size() && k <= int'(l); k++) begin
          nchk++;
          if (rsps[k].d !== exp_d[k] || rsps[k].last !== (k == int'(l)) || rsps[k].cyc !== acc + 2 + RL + k)
            $display("FAIL rnd%0d_rsp%0d: got d%h last%b cyc%0d want d%h last%b cyc%0d", n, k,
                     rsps[k].d, rsps[k].last, rsps[k].cyc, exp_d[k], k == int'(l), acc + 2 + RL + k);
          else npass++;
        end
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.req_wdata = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
    test_reset();
    test_single_write();
    test_burst_rw();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_INITIATOR_STATS_EN
    test_stats();
`endif
    test_random();
    nchk++; if (proto_err !== 0) $display("FAIL protocol: got %0d violations want 0", proto_err); else npass++;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
